// File: rtl/rv_decode_nibble_alu.sv
// ---------------------------------------------------------------------------
// rv_decode_nibble_alu
//
// Purpose:
//   RV32I instruction-field decoder combined with a nibble-serial 32-bit ALU.
//
//   The decoder is purely combinational. It works from the latched
//   instruction word and is not affected by reset.
//
//   The ALU processes one NIBBLE_W-bit slice per clock, LSB slice first.
//   A full word takes XLEN/NIBBLE_W cycles. While the ALU is running it
//   holds the host FSM with busy.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   instr         instruction word
//   op_code       instr[6:0]
//   rs1/rs2/rd    register index fields
//   imm           sign-extended immediate for the op_code's format
//   jump_addr     B-type offset {instr[31],instr[7],instr[30:25],instr[11:8]}
//   alu_cmd       decoded ALU op for OP/OP_IMM
//                 (ADD=0, SUB=1, AND=2, OR=3, XOR=4)
//   ctrl          ALU op for the current run (same encoding as alu_cmd)
//   word1/word2   ALU operands; they must stay stable while busy
//   perm_to_count request to run the ALU
//   busy          ALU operation in progress
//   result        ALU result register
// ---------------------------------------------------------------------------
module rv_decode_nibble_alu #(
    parameter int XLEN     = 32,
    parameter int NIBBLE_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr,
    output logic [6:0]      op_code,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [11:0]     jump_addr,
    output logic [2:0]      alu_cmd,
    input  logic [2:0]      ctrl,
    input  logic [XLEN-1:0] word1,
    input  logic [XLEN-1:0] word2,
    input  logic            perm_to_count,
    output logic            busy,
    output logic [XLEN-1:0] result
);

    localparam int N_NIB = XLEN / NIBBLE_W;
    localparam int IDX_W = $clog2(N_NIB);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_AND = 3'd2;
    localparam logic [2:0] CMD_OR  = 3'd3;
    localparam logic [2:0] CMD_XOR = 3'd4;

    // ---------------- decoder ----------------
    logic [2:0] funct3_s;

    assign op_code   = instr[6:0];
    assign rd        = instr[11:7];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign funct3_s  = instr[14:12];
    assign jump_addr = {instr[31], instr[7], instr[30:25], instr[11:8]};

    // Immediate selection by instruction format
    always_comb begin
        imm = 32'd0;
        case (op_code)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'd0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

    // ALU command decode; only register/immediate ALU ops select anything other than ADD
    always_comb begin
        alu_cmd = CMD_ADD;
        if ((op_code == OPC_OP) || (op_code == OPC_OP_IMM)) begin
            case (funct3_s)
                3'b000: begin
                    // instr[30] distinguishes SUB from ADD, but only in the register form
                    if ((op_code == OPC_OP) && instr[30]) begin
                        alu_cmd = CMD_SUB;
                    end else begin
                        alu_cmd = CMD_ADD;
                    end
                end
                3'b111:  alu_cmd = CMD_AND;
                3'b110:  alu_cmd = CMD_OR;
                3'b100:  alu_cmd = CMD_XOR;
                default: alu_cmd = CMD_ADD;
            endcase
        end else begin
            alu_cmd = CMD_ADD;
        end
    end

    // ---------------- nibble-serial ALU ----------------
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic                done_q,   done_d;
    logic                carry_q,  carry_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic [NIBBLE_W-1:0] nib_a_s;
    logic [NIBBLE_W-1:0] nib_b_s;
    logic [NIBBLE_W-1:0] nib_r_s;
    logic [NIBBLE_W:0]   sum_s;
    logic                cin_s;
    logic                is_sub_s;
    int                  base_s;

    // busy is gated by rst_n so it drops at once while reset is asserted
    assign busy   = perm_to_count & ~done_q & rst_n;
    assign result = result_q;

    // Nibble datapath: one add/sub or logic slice selected by the current index
    always_comb begin
        base_s   = int'(idx_q) * NIBBLE_W;
        is_sub_s = (ctrl == CMD_SUB);
        nib_a_s  = word1[base_s +: NIBBLE_W];
        nib_b_s  = is_sub_s ? ~word2[base_s +: NIBBLE_W] : word2[base_s +: NIBBLE_W];
        // Force the first carry-in so a stale carry can never leak into a new run
        if (idx_q == '0) begin
            cin_s = is_sub_s;
        end else begin
            cin_s = carry_q;
        end
        sum_s = {1'b0, nib_a_s} + {1'b0, nib_b_s} + {{NIBBLE_W{1'b0}}, cin_s};
        case (ctrl)
            CMD_AND: nib_r_s = word1[base_s +: NIBBLE_W] & word2[base_s +: NIBBLE_W];
            CMD_OR:  nib_r_s = word1[base_s +: NIBBLE_W] | word2[base_s +: NIBBLE_W];
            CMD_XOR: nib_r_s = word1[base_s +: NIBBLE_W] ^ word2[base_s +: NIBBLE_W];
            default: nib_r_s = sum_s[NIBBLE_W-1:0];
        endcase
    end

    // Next-state logic for index, done flag, carry and result
    always_comb begin
        idx_d    = idx_q;
        done_d   = done_q;
        carry_d  = carry_q;
        result_d = result_q;
        if (!perm_to_count) begin
            // Idle or abort: sequencing state clears, result is retained
            idx_d   = '0;
            done_d  = 1'b0;
            carry_d = 1'b0;
        end else if (!done_q) begin
            result_d[base_s +: NIBBLE_W] = nib_r_s;
            if (idx_q == IDX_W'(N_NIB - 1)) begin
                // Final carry-out is dropped: the result wraps mod 2^XLEN
                idx_d   = '0;
                done_d  = 1'b1;
                carry_d = 1'b0;
            end else begin
                idx_d   = idx_q + 1'b1;
                done_d  = 1'b0;
                carry_d = sum_s[NIBBLE_W];
            end
        end else begin
            // Completed and still requested: hold everything until the request drops
            idx_d   = idx_q;
            done_d  = done_q;
            carry_d = carry_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            idx_q    <= idx_d;
            done_q   <= done_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_rv_decode_nibble_alu.sv
// ---------------------------------------------------------------------------
// tb_rv_decode_nibble_alu
//
// Self-checking bench for rv_decode_nibble_alu.
// Decoder fields are compared against a reference built from signed
// arithmetic shifts. ALU results are compared against whole-word arithmetic.
// ---------------------------------------------------------------------------
module tb_rv_decode_nibble_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [6:0]  op_code;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [11:0] jump_addr;
    logic [2:0]  alu_cmd;
    logic [2:0]  ctrl;
    logic [31:0] word1;
    logic [31:0] word2;
    logic        perm_to_count;
    logic        busy;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    rv_decode_nibble_alu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .op_code       (op_code),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .imm           (imm),
        .jump_addr     (jump_addr),
        .alu_cmd       (alu_cmd),
        .ctrl          (ctrl),
        .word1         (word1),
        .word2         (word2),
        .perm_to_count (perm_to_count),
        .busy          (busy),
        .result        (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference immediate: sign extension done by arithmetic right shift of the whole word
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int s;
        s = $signed(i);
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                return 32'(s >>> 20);
            7'b0100011:
                return 32'((s >>> 25) <<< 5) | 32'(i[11:7]);
            7'b1100011:
                return 32'((s >>> 31) <<< 12) | (32'(i[7]) << 11) |
                       (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            7'b0110111, 7'b0010111:
                return i & 32'hFFFF_F000;
            7'b1101111:
                return 32'((s >>> 31) <<< 20) | (32'(i[19:12]) << 12) |
                       (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default:
                return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_cmd(input logic [31:0] i);
        logic is_op;
        logic is_imm;
        is_op  = (i[6:0] == 7'b0110011);
        is_imm = (i[6:0] == 7'b0010011);
        if (!(is_op || is_imm)) return 3'd0;
        case (i[14:12])
            3'b000:  return (is_op && i[30]) ? 3'd1 : 3'd0;
            3'b111:  return 3'd2;
            3'b110:  return 3'd3;
            3'b100:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    task automatic check_decode(input string tag, input logic [31:0] i);
        instr = i;
        #1;
        check({tag, "_opcode"}, 32'(op_code), 32'(i[6:0]));
        check({tag, "_rd"}, 32'(rd), 32'(i[11:7]));
        check({tag, "_rs1"}, 32'(rs1), 32'(i[19:15]));
        check({tag, "_rs2"}, 32'(rs2), 32'(i[24:20]));
        check({tag, "_imm"}, imm, ref_imm(i));
        check({tag, "_jaddr"}, 32'(jump_addr), 32'({i[31], i[7], i[30:25], i[11:8]}));
        check({tag, "_cmd"}, 32'(alu_cmd), 32'(ref_cmd(i)));
    endtask

    // Full run: count edges until busy falls, check the result,
    // check that it is held while the request stays high, then drop the request.
    task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int edges;
        logic [31:0] exp;
        exp = ref_alu(c, a, b);
        @(negedge clk);
        ctrl = c;
        word1 = a;
        word2 = b;
        perm_to_count = 1'b1;
        #1;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        edges = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            edges = n;
            if (!busy) break;
        end
        check({tag, "_edges"}, 32'(edges), 32'd8);
        check({tag, "_result"}, result, exp);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_busy"}, 32'(busy), 32'd0);
        check({tag, "_hold_result"}, result, exp);
        @(negedge clk);
        perm_to_count = 1'b0;
        @(negedge clk);
    endtask

    logic [6:0] opcodes [11];

    initial begin
        opcodes = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b0110111,
                    7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011,
                    7'b1111111};
        rst_n = 1'b0;
        instr = 32'd0;
        ctrl = 3'd0;
        word1 = 32'd0;
        word2 = 32'd0;
        perm_to_count = 1'b0;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed decoder vectors
        check_decode("addi_x5", 32'h07B00293);
        check("addi_x5_imm_val", imm, 32'd123);
        check("addi_x5_cmd_val", 32'(alu_cmd), 32'd0);
        check_decode("addi_x6", 32'h00228313);
        check("addi_x6_rs1_val", 32'(rs1), 32'd5);
        check("addi_x6_rd_val", 32'(rd), 32'd6);
        check_decode("ecall", 32'h00000073);
        check("ecall_opcode_val", 32'(op_code), 32'h73);
        check("ecall_imm_val", imm, 32'd0);
        check_decode("sub", 32'h40B50533);
        check("sub_cmd_val", 32'(alu_cmd), 32'd1);

        // Randomized decoder vectors across all formats
        for (int k = 0; k < 24; k++) begin
            logic [31:0] r;
            r = $urandom;
            r[6:0] = opcodes[k % 11];
            check_decode("rand_dec", r);
        end

        // Directed ALU runs
        run_op("add_123_2", 3'd0, 32'd123, 32'd2);
        check("add_123_2_val", result, 32'd125);
        run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap_val", result, 32'd0);
        run_op("sub_5_7", 3'd1, 32'd5, 32'd7);
        check("sub_5_7_val", result, 32'hFFFF_FFFE);
        run_op("xor", 3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
        check("xor_val", result, 32'h0F0F_F0F0);
        run_op("and", 3'd2, 32'hDEAD_BEEF, 32'h0FF0_F00F);
        run_op("or", 3'd3, 32'h1234_0000, 32'h0000_5678);

        // Randomized ALU runs
        for (int k = 0; k < 10; k++) begin
            run_op("rand_alu", 3'($urandom_range(0, 4)), $urandom, $urandom);
        end

        // Abort mid-operation by dropping the request, then a fresh run
        @(negedge clk);
        ctrl = 3'd0;
        word1 = 32'h1111_1111;
        word2 = 32'h2222_2222;
        perm_to_count = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        perm_to_count = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        run_op("after_abort", 3'd1, 32'h0000_1000, 32'h0000_0001);

        // Asynchronous reset at nibble 3
        @(negedge clk);
        ctrl = 3'd0;
        word1 = 32'hAAAA_AAAA;
        word2 = 32'h1111_1111;
        perm_to_count = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_result", result, 32'd0);
        perm_to_count = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_reset", 3'd0, 32'hAAAA_AAAA, 32'h1111_1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
